// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Raster timing generator for the VGA display path. One pixel per in_clk
// cycle. Produces the current pixel coordinate plus the sync, display-enable
// and end-of-line / end-of-frame markers that describe that coordinate.
// Default parameters give 640x480 @ 60 Hz from a 25 MHz pixel clock.
//
// Every output is registered from the same next-state values, so in any
// cycle x_out, y_out, hsync, vsync, display_en, line_done, frame_done and
// frame_cnt all describe the same pixel (zero relative latency).
//
// Ports
//   in_clk      in   1   pixel clock
//   reset       in   1   asynchronous, active-low reset
//   x_out       out  10  horizontal count, 0..H_TOTAL-1
//   y_out       out  10  vertical count, 0..V_TOTAL-1
//   hsync       out  1   SYNC_ACTIVE during horizontal sync, else inverted
//   vsync       out  1   SYNC_ACTIVE during vertical sync lines, else inverted
//   display_en  out  1   high when (x_out, y_out) is a visible pixel
//   line_done   out  1   high on the last pixel of every line
//   frame_done  out  1   high on the last pixel of every frame
//   frame_cnt   out  8   frames completed since reset, modulo 256
//
// Horizontal machine
//   state | meaning
//   H_VIS | visible pixels,    x = 0 .. H_VISIBLE-1
//   H_FP  | front porch,       next H_FRONT pixels
//   H_SP  | sync pulse,        next H_SYNC pixels
//   H_BP  | back porch,        last H_BACK pixels, up to H_TOTAL-1
//
// Vertical machine (advances only on the cycle x wraps)
//   state | meaning
//   V_VIS | visible lines,     y = 0 .. V_VISIBLE-1
//   V_FP  | front porch,       next V_FRONT lines
//   V_SP  | sync pulse,        next V_SYNC lines
//   V_BP  | back porch,        last V_BACK lines, up to V_TOTAL-1
//
// H_TOTAL and V_TOTAL must not exceed 1024 and every phase must be at least
// one count long; other settings are unsupported.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       in_clk,
  input  logic       reset,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       line_done,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each phase; a machine leaves a phase on the cycle its
  // counter sits on that value.
  localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] H_FP_LAST  = 10'(H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0] H_SP_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_FP_LAST  = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0] V_SP_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    H_VIS = 2'd0,
    H_FP  = 2'd1,
    H_SP  = 2'd2,
    H_BP  = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_VIS = 2'd0,
    V_FP  = 2'd1,
    V_SP  = 2'd2,
    V_BP  = 2'd3
  } v_state_t;

  h_state_t   h_state;
  h_state_t   h_next;
  v_state_t   v_state;
  v_state_t   v_next;

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       x_wrap;
  logic       frame_wrap;

  logic       hsync_next;
  logic       vsync_next;
  logic       display_en_next;
  logic       line_done_next;
  logic       frame_done_next;
  logic [7:0] frame_cnt_next;

  // ---------------------------------------------------------------------------
  // State register: both machines, both counters and every output flop.
  // Reset is asynchronous so a reset in the middle of a sync pulse ends the
  // pulse immediately instead of at the next edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      h_state    <= H_VIS;
      v_state    <= V_VIS;
      x_out      <= '0;
      y_out      <= '0;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
      display_en <= 1'b1;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      h_state    <= h_next;
      v_state    <= v_next;
      x_out      <= x_next;
      y_out      <= y_next;
      hsync      <= hsync_next;
      vsync      <= vsync_next;
      display_en <= display_en_next;
      line_done  <= line_done_next;
      frame_done <= frame_done_next;
      frame_cnt  <= frame_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: counters and phase machines.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_wrap     = (x_out == H_LAST);
    frame_wrap = x_wrap && (y_out == V_LAST);

    x_next = x_wrap ? '0 : x_out + 10'd1;

    y_next = y_out;
    if (x_wrap) begin
      y_next = (y_out == V_LAST) ? '0 : y_out + 10'd1;
    end

    h_next = h_state;
    case (h_state)
      H_VIS:   if (x_out == H_VIS_LAST) h_next = H_FP;
      H_FP:    if (x_out == H_FP_LAST)  h_next = H_SP;
      H_SP:    if (x_out == H_SP_LAST)  h_next = H_BP;
      H_BP:    if (x_wrap)              h_next = H_VIS;
      default:                          h_next = H_VIS;
    endcase

    // Vertical phase only moves on the x wrap, which makes vsync line-based.
    v_next = v_state;
    if (x_wrap) begin
      case (v_state)
        V_VIS:   if (y_out == V_VIS_LAST) v_next = V_FP;
        V_FP:    if (y_out == V_FP_LAST)  v_next = V_SP;
        V_SP:    if (y_out == V_SP_LAST)  v_next = V_BP;
        V_BP:    if (y_out == V_LAST)     v_next = V_VIS;
        default:                          v_next = V_VIS;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so that, once registered, each
  // output lines up with the coordinate registered on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    hsync_next      = (h_next == H_SP) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_next      = (v_next == V_SP) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    display_en_next = (h_next == H_VIS) && (v_next == V_VIS);
    line_done_next  = (x_next == H_LAST);
    frame_done_next = (x_next == H_LAST) && (y_next == V_LAST);

    // Count the frame on the edge that leaves its last pixel, so the new
    // count appears together with coordinate (0, 0).
    frame_cnt_next = frame_wrap ? frame_cnt + 8'd1 : frame_cnt;
  end

endmodule
